// File: rtl/axis_m_packet_tx.sv
// rtl/axis_m_packet_tx.sv - AXI4-Stream master packet transmitter fed from a word FIFO
//
// Pops packed words from the shared word FIFO and emits one packet of pkt_bytes
// bytes on M_AXIS. Every beat is full except the last, which carries a
// low-justified partial TKEEP and TLAST.
//
// Ports:
//   M_AXIS_ACLK, M_AXIS_ARESETN   clock (rising edge), async active-low reset
//   start, pkt_bytes              1-cycle start pulse and byte length sampled with it
//   busy, done, sent_beats        status: packet in flight, completion pulse, beat count
//   fifo_pop, fifo_empty,         FIFO read strobe (combinational), empty flag,
//   fifo_rdata                    read data valid the cycle after fifo_pop
//   M_AXIS_T*                     AXI4-Stream master beat interface

module axis_m_packet_tx #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DATA_WIDTH      = 32,
    parameter int PKT_LEN_WIDTH        = 16
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESETN,
    input  logic                              start,
    input  logic [PKT_LEN_WIDTH-1:0]          pkt_bytes,
    output logic                              busy,
    output logic                              done,
    output logic [PKT_LEN_WIDTH-1:0]          sent_beats,
    output logic                              fifo_pop,
    input  logic                              fifo_empty,
    input  logic [FIFO_DATA_WIDTH-1:0]        fifo_rdata,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY
);

    localparam int BPB  = C_M_AXIS_TDATA_WIDTH / 8;
    localparam int LOG2 = $clog2(BPB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t                            r_state;
    state_t                            w_next;

    logic [PKT_LEN_WIDTH-1:0]          r_beats_left;
    logic [PKT_LEN_WIDTH-1:0]          r_sent_beats;
    logic [BPB-1:0]                    r_last_keep;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_tvalid;
    logic                              r_tlast;
    logic [BPB-1:0]                    r_tkeep;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   r_tdata;

    logic                              w_start_ok;
    logic                              w_hs;
    logic                              w_pop;
    logic                              w_is_last;
    logic [PKT_LEN_WIDTH:0]            w_sum;
    logic [LOG2-1:0]                   w_rem;
    logic [BPB-1:0]                    w_last_keep;
    logic [BPB-1:0]                    w_keep_load;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]   w_mask;

    assign w_start_ok = start && (pkt_bytes != '0);
    assign w_hs       = r_tvalid && M_AXIS_TREADY;
    assign w_is_last  = (r_beats_left == PKT_LEN_WIDTH'(1));

    // One extra bit so the round-up never wraps at the maximum length.
    assign w_sum       = {1'b0, pkt_bytes} + (PKT_LEN_WIDTH + 1)'(BPB - 1);
    assign w_rem       = pkt_bytes[LOG2-1:0];
    assign w_last_keep = (w_rem == '0) ? {BPB{1'b1}} : ~({BPB{1'b1}} << w_rem);
    assign w_keep_load = w_is_last ? r_last_keep : {BPB{1'b1}};

    // Bytes outside TKEEP are forced to zero so the tail beat carries no stale data.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < BPB; i++) begin
            w_mask[i*8 +: 8] = {8{w_keep_load[i]}};
        end
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_pop = !fifo_empty;
                if (!fifo_empty) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = S_SEND;
            end
            S_SEND: begin
                if (w_hs) begin
                    w_next = r_tlast ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_beats_left <= '0;
            r_sent_beats <= '0;
            r_last_keep  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_tkeep      <= '0;
            r_tdata      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_beats_left <= PKT_LEN_WIDTH'(w_sum >> LOG2);
                        r_last_keep  <= w_last_keep;
                        r_sent_beats <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_tdata  <= fifo_rdata & w_mask;
                    r_tkeep  <= w_keep_load;
                    r_tlast  <= w_is_last;
                    r_tvalid <= 1'b1;
                end
                S_SEND: begin
                    if (w_hs) begin
                        r_sent_beats <= r_sent_beats + 1'b1;
                        r_beats_left <= r_beats_left - 1'b1;
                        r_tvalid     <= 1'b0;
                        r_tlast      <= 1'b0;
                        r_done       <= r_tlast;
                    end
                end
                S_DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign sent_beats    = r_sent_beats;
    assign fifo_pop      = w_pop;
    assign M_AXIS_TVALID = r_tvalid;
    assign M_AXIS_TDATA  = r_tdata;
    assign M_AXIS_TKEEP  = r_tkeep;
    assign M_AXIS_TLAST  = r_tlast;

endmodule

// File: tb/tb_axis_m_packet_tx.sv
// tb/tb_axis_m_packet_tx.sv - directed self-checking bench for axis_m_packet_tx

module tb_axis_m_packet_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pkt_bytes = '0;
    logic        busy;
    logic        done;
    logic [15:0] sent_beats;
    logic        fifo_pop;
    logic        fifo_empty;
    logic [31:0] fifo_rdata = '0;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_m_packet_tx dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rst_n),
        .start          (start),
        .pkt_bytes      (pkt_bytes),
        .busy           (busy),
        .done           (done),
        .sent_beats     (sent_beats),
        .fifo_pop       (fifo_pop),
        .fifo_empty     (fifo_empty),
        .fifo_rdata     (fifo_rdata),
        .M_AXIS_TVALID  (tvalid),
        .M_AXIS_TDATA   (tdata),
        .M_AXIS_TKEEP   (tkeep),
        .M_AXIS_TLAST   (tlast),
        .M_AXIS_TREADY  (tready)
    );

    // FIFO model: written from the stimulus block, read by the DUT.
    logic [31:0] mem [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_pop) begin
            fifo_rdata <= mem[rd_ptr % 64];
            rd_ptr     <= rd_ptr + 1;
            pop_cnt    <= pop_cnt + 1;
        end
    end

    // Stream monitor.
    logic [31:0] cap_data [64];
    logic [3:0]  cap_keep [64];
    logic        cap_last [64];
    int cap_n = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    int done_cnt = 0;
    int done_gap = 0;
    int stall_err = 0;
    int stall_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] pd = '0;
    logic [3:0]  pk = '0;
    logic        pl = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tvalid && tready) begin
            cap_data[cap_n % 64] <= tdata;
            cap_keep[cap_n % 64] <= tkeep;
            cap_last[cap_n % 64] <= tlast;
            cap_n       <= cap_n + 1;
            last_hs_cyc <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_gap <= cyc - last_hs_cyc;
        end
        if (rst_n && prev_stall && (!tvalid || tdata !== pd || tkeep !== pk || tlast !== pl)) begin
            stall_err <= stall_err + 1;
        end
        if (tvalid && !tready) begin
            stall_cyc <= stall_cyc + 1;
        end
        prev_stall <= rst_n && tvalid && !tready;
        pd <= tdata;
        pk <= tkeep;
        pl <= tlast;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr++;
    endtask

    task automatic send_start(input logic [15:0] n);
        @(negedge clk);
        pkt_bytes = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for the done pulse, then steps one more cycle so the DUT is idle.
    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {31'b0, seen}, 32'd1);
        @(negedge clk);
    endtask

    int b, d0, p0, s0, viol;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_tvalid", {31'b0, tvalid}, 32'd0);
        check("rst_tlast", {31'b0, tlast}, 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_tkeep", {28'b0, tkeep}, 32'd0);
        check("rst_sent", {16'b0, sent_beats}, 32'd0);
        check("rst_pop", {31'b0, fifo_pop}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: four full beats, latency and done timing
        push(32'h01010101); push(32'h02020202); push(32'h03030303); push(32'h04040404);
        b = cap_n; d0 = done_cnt;
        send_start(16'd16);
        check("t1_busy", {31'b0, busy}, 32'd1);
        check("t1_pop_fetch", {31'b0, fifo_pop}, 32'd1);
        check("t1_tvalid_c1", {31'b0, tvalid}, 32'd0);
        @(negedge clk);
        check("t1_tvalid_c2", {31'b0, tvalid}, 32'd0);
        @(negedge clk);
        check("t1_tvalid_c3", {31'b0, tvalid}, 32'd1);
        wait_done("t1_done_seen", 100);
        check("t1_beats", cap_n - b, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_data", cap_data[b+i], {4{8'(i+1)}});
            check("t1_keep", {28'b0, cap_keep[b+i]}, 32'hF);
            check("t1_last", {31'b0, cap_last[b+i]}, (i == 3) ? 32'd1 : 32'd0);
        end
        check("t1_done_gap", done_gap, 32'd1);
        check("t1_done_cnt", done_cnt - d0, 32'd1);
        check("t1_done_low", {31'b0, done}, 32'd0);
        check("t1_busy_low", {31'b0, busy}, 32'd0);
        check("t1_sent", {16'b0, sent_beats}, 32'd4);

        // 2: partial tail beats
        for (int i = 0; i < 9; i++) push(32'hAAAAAAAA);
        b = cap_n;
        send_start(16'd35);
        wait_done("t2a_done_seen", 200);
        check("t2a_beats", cap_n - b, 32'd9);
        check("t2a_keep7", {28'b0, cap_keep[b+7]}, 32'hF);
        check("t2a_last7", {31'b0, cap_last[b+7]}, 32'd0);
        check("t2a_keep8", {28'b0, cap_keep[b+8]}, 32'h7);
        check("t2a_data8", cap_data[b+8], 32'h00AAAAAA);
        check("t2a_last8", {31'b0, cap_last[b+8]}, 32'd1);
        check("t2a_sent", {16'b0, sent_beats}, 32'd9);
        for (int i = 0; i < 9; i++) push(32'hAAAAAAAA);
        b = cap_n;
        send_start(16'd33);
        wait_done("t2b_done_seen", 200);
        check("t2b_beats", cap_n - b, 32'd9);
        check("t2b_keep8", {28'b0, cap_keep[b+8]}, 32'h1);
        check("t2b_data8", cap_data[b+8], 32'h000000AA);
        check("t2b_last8", {31'b0, cap_last[b+8]}, 32'd1);

        // 3: backpressure
        push(32'h11111111); push(32'h22222222); push(32'h33333333); push(32'h44444444);
        b = cap_n; p0 = pop_cnt; s0 = stall_cyc; viol = stall_err;
        send_start(16'd16);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 300; i++) begin
                tready = (i % 4 == 0 || i % 4 == 3) ? 1'b1 : ((i % 16) > 11 ? 1'(($urandom_range(0, 1))) : 1'b0);
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("t3_done_seen", {31'b0, seen}, 32'd1);
        end
        tready = 1'b1;
        @(negedge clk);
        check("t3_stalled", {31'b0, (stall_cyc - s0) > 0}, 32'd1);
        check("t3_stable", stall_err - viol, 32'd0);
        check("t3_pops", pop_cnt - p0, 32'd4);
        check("t3_beats", cap_n - b, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t3_data", cap_data[b+i], {4{8'(8'h11 * (i+1))}});
        end
        check("t3_last3", {31'b0, cap_last[b+3]}, 32'd1);

        // 4: FIFO runs dry mid-packet
        push(32'hC0C0C0C0); push(32'hC1C1C1C1);
        b = cap_n; viol = 0;
        send_start(16'd16);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_empty && fifo_pop) viol++;
        end
        check("t4_no_underflow", viol, 32'd0);
        check("t4_tvalid_wait", {31'b0, tvalid}, 32'd0);
        check("t4_pop_wait", {31'b0, fifo_pop}, 32'd0);
        check("t4_busy_wait", {31'b0, busy}, 32'd1);
        check("t4_sent_wait", {16'b0, sent_beats}, 32'd2);
        push(32'hC2C2C2C2); push(32'hC3C3C3C3);
        wait_done("t4_done_seen", 100);
        check("t4_beats", cap_n - b, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t4_data", cap_data[b+i], {4{8'(8'hC0 + i)}});
        end
        check("t4_last3", {31'b0, cap_last[b+3]}, 32'd1);
        check("t4_last2", {31'b0, cap_last[b+2]}, 32'd0);

        // 5: reset while a beat is presented
        push(32'h55555555); push(32'h66666666); push(32'h77777777); push(32'h88888888);
        tready = 1'b0;
        send_start(16'd16);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (tvalid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("t5_tvalid_seen", {31'b0, seen}, 32'd1);
        end
        check("t5_tdata_pre", tdata, 32'h55555555);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_tvalid", {31'b0, tvalid}, 32'd0);
        check("t5_rst_tlast", {31'b0, tlast}, 32'd0);
        check("t5_rst_busy", {31'b0, busy}, 32'd0);
        check("t5_rst_tdata", tdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tready = 1'b1;
        b = cap_n;
        send_start(16'd8);
        wait_done("t5_done_seen", 100);
        check("t5_beats", cap_n - b, 32'd2);
        check("t5_data0", cap_data[b], 32'h66666666);
        check("t5_data1", cap_data[b+1], 32'h77777777);
        check("t5_last1", {31'b0, cap_last[b+1]}, 32'd1);
        check("t5_sent", {16'b0, sent_beats}, 32'd2);

        // 6: zero-length start and start while busy
        p0 = pop_cnt;
        send_start(16'd0);
        repeat (3) @(negedge clk);
        check("t6_zero_busy", {31'b0, busy}, 32'd0);
        check("t6_zero_pops", pop_cnt - p0, 32'd0);
        push(32'h99999999);
        b = cap_n; d0 = done_cnt;
        send_start(16'd8);
        @(negedge clk);
        send_start(16'd16);
        wait_done("t6_done_seen", 100);
        repeat (5) @(negedge clk);
        check("t6_done_cnt", done_cnt - d0, 32'd1);
        check("t6_busy_after", {31'b0, busy}, 32'd0);
        check("t6_beats", cap_n - b, 32'd2);
        check("t6_data0", cap_data[b], 32'h88888888);
        check("t6_data1", cap_data[b+1], 32'h99999999);
        check("t6_sent", {16'b0, sent_beats}, 32'd2);
        check("t6_pops", pop_cnt - p0, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
